// File: rtl/tbus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tbus_pkg
// Shared types and helpers for the tristate-bus arbiter and for other blocks
// that reuse its round-robin picker.
//   state_e    : arbiter FSM states (IDLE, SETTLE, XFER, CLOSE, DEAD)
//   clog2      : ceiling log2 for elaboration-time width computation
//   ptr_w      : width of a requester index for n requesters
//   cnt_w      : width of a counter that must hold the value max_val
//   onehot     : one-hot vector (MAX_REQ bits) with bit idx set
// -----------------------------------------------------------------------------
package tbus_pkg;

  // Widest requester vector any instance may use.
  localparam int MAX_REQ = 8;

  // Default instance configuration.
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DEAD_CYCLES = 1;
  localparam int DEF_MAX_HOLD    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    XFER   = 3'd2,
    CLOSE  = 3'd3,
    DEAD   = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int ptr_w(input int n);
    return clog2(n);
  endfunction

  function automatic int cnt_w(input int max_val);
    return clog2(max_val + 1);
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/tbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// tbus_arbiter_if
// Bundle between the requesters / driver banks and the tristate-bus arbiter.
//   req        : level requests, bit i = requester i wants the bus
//   gnt        : one-hot current owner, 0 while the bus is unowned
//   drv_en     : TINV EN per driver bank
//   drv_nen    : TINV nEN per driver bank, always ~drv_en
//   lat_clk    : destination latch CLK (transparent while high)
//   lat_nclk   : always ~lat_clk
//   busy       : arbiter is in any state other than IDLE
//   dbg_state  : current FSM state, for observation only
//   dbg_rr_ptr : current round-robin start index, for observation only
//
// Request/grant protocol: req[i] is a level, not a pulse, and is never
// latched. The arbiter samples req only when it arbitrates (in IDLE and on
// the last DEAD cycle); a request that drops before it is granted is lost.
// Once granted, the owner keeps the bus while req[i] stays high, up to the
// hold limit, and gives it up the cycle after req[i] is sampled low.
// Every output is registered, so there is no path from req to any output
// within a cycle.
// -----------------------------------------------------------------------------
interface tbus_arbiter_if import tbus_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ
);

  localparam int PTR_W = ptr_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] drv_en;
  logic [N_REQ-1:0] drv_nen;
  logic             lat_clk;
  logic             lat_nclk;
  logic             busy;
  state_e           dbg_state;
  logic [PTR_W-1:0] dbg_rr_ptr;

  // Requester / bench side.
  modport master (
    output req,
    input  gnt, drv_en, drv_nen, lat_clk, lat_nclk, busy, dbg_state, dbg_rr_ptr
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt, drv_en, drv_nen, lat_clk, lat_nclk, busy, dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/tbus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of req_i found
// scanning upward from rr_ptr_i and wrapping around.
//   req_i    : request vector
//   rr_ptr_i : index with highest priority this round
//   win_o    : index of the winner (0 when valid_o is low)
//   valid_o  : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick import tbus_pkg::*; #(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [PTR_W-1:0] win_o,
  output logic             valid_o
);

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    // Offset k walks the ring starting at rr_ptr_i; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid_o && req_i[(int'(rr_ptr_i) + k) % N_REQ]) begin
        win_o   = PTR_W'((int'(rr_ptr_i) + k) % N_REQ);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// -----------------------------------------------------------------------------
// tbus_arbiter
// Round-robin arbiter for a shared internal tristate bus built from TINV
// driver banks, with a D-latch destination register.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : tbus_arbiter_if.slave (req in; gnt, drv_en/nen, lat_clk/nclk,
//            busy and debug state out)
//
// Grant sequence per owner:
//   SETTLE : driver bank on, latch closed; bus settles
//   XFER   : driver bank on, latch transparent; up to MAX_HOLD cycles
//   CLOSE  : latch closes while the driver still holds the data
//   DEAD   : all drivers off for DEAD_CYCLES (break-before-make)
// -----------------------------------------------------------------------------
module tbus_arbiter import tbus_pkg::*; #(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  tbus_arbiter_if.slave bus
);

  localparam int PTR_W  = ptr_w(N_REQ);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam int DEAD_W = cnt_w(DEAD_CYCLES);

  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
  localparam logic [DEAD_W-1:0] DEAD_LIM  = DEAD_W'(DEAD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,   state_d;
  logic [PTR_W-1:0]  owner_q,   owner_d;
  logic [PTR_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic [DEAD_W-1:0] dead_q,    dead_d;

  // Registered outputs.
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  drv_en_q;
  logic [N_REQ-1:0]  drv_nen_q;
  logic              lat_clk_q;
  logic              lat_nclk_q;
  logic              busy_q;

  // Next values of the output registers.
  logic [N_REQ-1:0]  en_d;
  logic              lat_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  pick_oh;
  logic [PTR_W-1:0]  next_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign owner_oh = N_REQ'(onehot(int'(owner_q)));
  assign pick_oh  = N_REQ'(onehot(int'(pick_idx)));
  // The released owner drops to lowest priority for the next round.
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic. en_d/lat_d describe the outputs of the state being
  // entered, so the registered outputs line up with state_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    dead_d   = dead_q;
    en_d     = '0;
    lat_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SETTLE;
          owner_d = pick_idx;
          en_d    = pick_oh;
        end
      end

      // The owner's request is not looked at here: every grant gets at
      // least one transparent latch cycle.
      SETTLE: begin
        state_d = XFER;
        hold_d  = HOLD_ONE;
        en_d    = owner_oh;
        lat_d   = 1'b1;
      end

      // hold_q counts XFER cycles already spent, starting at 1.
      XFER: begin
        en_d = owner_oh;
        if (!bus.req[owner_q] || (hold_q == HOLD_LIM)) begin
          state_d  = CLOSE;
          rr_ptr_d = next_ptr;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
          lat_d  = 1'b1;
        end
      end

      // Driver stays on for one cycle after the latch closes so the latch
      // never sees the bus float while transparent.
      CLOSE: begin
        state_d = DEAD;
        dead_d  = DEAD_ONE;
      end

      DEAD: begin
        if (dead_q == DEAD_LIM) begin
          dead_d = '0;
          if (pick_valid) begin
            state_d = SETTLE;
            owner_d = pick_idx;
            en_d    = pick_oh;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_q + DEAD_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset drops every driver and closes the latch without a clock.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= '0;
      dead_q     <= '0;
      gnt_q      <= '0;
      drv_en_q   <= '0;
      drv_nen_q  <= '1;
      lat_clk_q  <= 1'b0;
      lat_nclk_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      dead_q     <= dead_d;
      gnt_q      <= en_d;
      drv_en_q   <= en_d;
      drv_nen_q  <= ~en_d;
      lat_clk_q  <= lat_d;
      lat_nclk_q <= ~lat_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt        = gnt_q;
  assign bus.drv_en     = drv_en_q;
  assign bus.drv_nen    = drv_nen_q;
  assign bus.lat_clk    = lat_clk_q;
  assign bus.lat_nclk   = lat_nclk_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tbus_arbiter
// Directed bench for tbus_arbiter: a default instance (4 requesters, 1 dead
// cycle, hold limit 8) and a second instance with DEAD_CYCLES=3.
// -----------------------------------------------------------------------------
module tb_tbus_arbiter;
  import tbus_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  tbus_arbiter_if #(.N_REQ(4)) bus  ();
  tbus_arbiter_if #(.N_REQ(4)) bus3 ();

  tbus_arbiter #(.N_REQ(4), .DEAD_CYCLES(1), .MAX_HOLD(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tbus_arbiter #(.N_REQ(4), .DEAD_CYCLES(3), .MAX_HOLD(8)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helpers
  // ---------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_sig(input string tag,
                         input logic [3:0] a_en, input logic [3:0] a_nen,
                         input logic [3:0] a_gnt, input logic a_lat,
                         input logic a_nclk, input logic a_busy,
                         input logic [3:0] en, input logic lat, input logic busy);
    logic [3:0] nen_e;
    logic       nclk_e;
    nen_e  = ~en;
    nclk_e = ~lat;
    chk({tag, ".drv_en"},   32'(a_en),   32'(en));
    chk({tag, ".drv_nen"},  32'(a_nen),  32'(nen_e));
    chk({tag, ".gnt"},      32'(a_gnt),  32'(en));
    chk({tag, ".lat_clk"},  32'(a_lat),  32'(lat));
    chk({tag, ".lat_nclk"}, 32'(a_nclk), 32'(nclk_e));
    chk({tag, ".busy"},     32'(a_busy), 32'(busy));
  endtask

  task automatic chk_main(input string tag, input logic [3:0] en, input logic lat,
                          input logic busy);
    chk_sig(tag, bus.drv_en, bus.drv_nen, bus.gnt, bus.lat_clk, bus.lat_nclk,
            bus.busy, en, lat, busy);
  endtask

  task automatic chk_d3(input string tag, input logic [3:0] en, input logic lat,
                        input logic busy);
    chk_sig(tag, bus3.drv_en, bus3.drv_nen, bus3.gnt, bus3.lat_clk, bus3.lat_nclk,
            bus3.busy, en, lat, busy);
  endtask

  // Apply req, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic [3:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Bus invariants, sampled on the falling edge
  // ---------------------------------------------------------------------------
  task automatic inv(input string tag, input logic [3:0] en, input logic [3:0] nen,
                     input logic [3:0] gnt, input logic lat, input logic nclk);
    chk({tag, ".one_driver"}, 32'($countones(en) <= 1), 32'(1));
    chk({tag, ".nen_compl"},  32'(nen),  32'(4'(~en)));
    chk({tag, ".nclk_compl"}, 32'(nclk), 32'(1'(~lat)));
    chk({tag, ".gnt_is_en"},  32'(gnt),  32'(en));
    chk({tag, ".lat_owned"},  32'(!lat || (en != 4'b0000)), 32'(1));
  endtask

  always @(negedge clk) begin
    inv("inv", bus.drv_en, bus.drv_nen, bus.gnt, bus.lat_clk, bus.lat_nclk);
    inv("inv3", bus3.drv_en, bus3.drv_nen, bus3.gnt, bus3.lat_clk, bus3.lat_nclk);
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic       lat;
    logic       busy;
    state_e     st;
    logic [1:0] rr;
  } vec_t;

  localparam int N_VEC = 19;
  vec_t tbl [N_VEC];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] oh;
    logic [3:0] e_en;
    logic       e_lat;
    logic       e_busy;
    logic [3:0] r3;
    int         gap;

    bus.req  = 4'b0000;
    bus3.req = 4'b0000;

    // Single requester 2 from IDLE: SETTLE, 4 XFER, CLOSE, DEAD, IDLE.
    tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, SETTLE, 2'd0};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, XFER,   2'd0};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, XFER,   2'd0};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, XFER,   2'd0};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, XFER,   2'd0};
    tbl[5]  = '{4'b0000, 4'b0100, 1'b0, 1'b1, CLOSE,  2'd3};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, DEAD,   2'd3};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, IDLE,   2'd3};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, IDLE,   2'd3};
    // Owner 1 drops while req[3] waits; req[3] rising mid-grant is ignored.
    tbl[9]  = '{4'b0010, 4'b0010, 1'b0, 1'b1, SETTLE, 2'd3};
    tbl[10] = '{4'b1010, 4'b0010, 1'b1, 1'b1, XFER,   2'd3};
    tbl[11] = '{4'b1010, 4'b0010, 1'b1, 1'b1, XFER,   2'd3};
    tbl[12] = '{4'b1000, 4'b0010, 1'b0, 1'b1, CLOSE,  2'd2};
    tbl[13] = '{4'b1000, 4'b0000, 1'b0, 1'b1, DEAD,   2'd2};
    tbl[14] = '{4'b1000, 4'b1000, 1'b0, 1'b1, SETTLE, 2'd2};
    tbl[15] = '{4'b1000, 4'b1000, 1'b1, 1'b1, XFER,   2'd2};
    tbl[16] = '{4'b0000, 4'b1000, 1'b0, 1'b1, CLOSE,  2'd0};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 1'b1, DEAD,   2'd0};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, IDLE,   2'd0};

    // --- Reset values appear with no clock edge ------------------------------
    #1 rst_n = 1'b0;
    #1;
    chk_main("rst0", 4'b0000, 1'b0, 1'b0);
    chk("rst0.state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst0.rr",    32'(bus.dbg_rr_ptr), 32'(0));
    chk_d3("rst0.d3", 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // --- Table-driven vectors -----------------------------------------------
    for (int i = 0; i < N_VEC; i++) begin
      step(tbl[i].req);
      chk_main($sformatf("tbl%0d", i), tbl[i].en, tbl[i].lat, tbl[i].busy);
      chk($sformatf("tbl%0d.state", i), 32'(bus.dbg_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.rr", i), 32'(bus.dbg_rr_ptr), 32'(tbl[i].rr));
    end

    // --- Reset in the middle of an owner-2 XFER -----------------------------
    step(4'b0100);
    step(4'b0100);
    step(4'b0100);
    chk("mid.state", 32'(bus.dbg_state), 32'(XFER));
    chk_main("mid", 4'b0100, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_main("mid_rst", 4'b0000, 1'b0, 1'b0);
    chk("mid_rst.state", 32'(bus.dbg_state), 32'(IDLE));
    #1 rst_n = 1'b1;
    // Arbitration restarts; requester 1 granted one edge later.
    step(4'b0010);
    chk_main("post_rst.settle", 4'b0010, 1'b0, 1'b1);
    // Minimum grant: req gone in SETTLE still gives one XFER cycle.
    step(4'b0000);
    chk_main("post_rst.xfer", 4'b0010, 1'b1, 1'b1);
    step(4'b0000);
    chk_main("post_rst.close", 4'b0010, 1'b0, 1'b1);
    step(4'b0000);
    chk_main("post_rst.dead", 4'b0000, 1'b0, 1'b1);
    step(4'b0000);
    chk_main("post_rst.idle", 4'b0000, 1'b0, 1'b0);
    chk("post_rst.rr", 32'(bus.dbg_rr_ptr), 32'(2));

    // Reset again so the next round starts from requester 0.
    rst_n = 1'b0;
    #1;
    chk("rst2.rr", 32'(bus.dbg_rr_ptr), 32'(0));
    #1 rst_n = 1'b1;

    // --- All four requesting: owners 0,1,2,3,0, each 8 XFER cycles ----------
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      step(4'b1111);
      chk_main($sformatf("all.g%0d.settle", g), oh, 1'b0, 1'b1);
      for (int x = 0; x < 8; x++) begin
        step(4'b1111);
        chk_main($sformatf("all.g%0d.xfer%0d", g, x), oh, 1'b1, 1'b1);
      end
      step(4'b1111);
      chk_main($sformatf("all.g%0d.close", g), oh, 1'b0, 1'b1);
      step(4'b1111);
      chk_main($sformatf("all.g%0d.dead", g), 4'b0000, 1'b0, 1'b1);
    end
    step(4'b0000);
    chk_main("all.idle", 4'b0000, 1'b0, 1'b0);

    // --- Sole requester 0 held 20 cycles: two forced releases ---------------
    for (int s = 1; s <= 23; s++) begin
      e_en = 4'b0000; e_lat = 1'b0; e_busy = 1'b1;
      if (s == 1 || s == 12)                             e_en = 4'b0001;
      else if ((s >= 2 && s <= 9) || (s >= 13 && s <= 20)) begin
        e_en = 4'b0001; e_lat = 1'b1;
      end
      else if (s == 10 || s == 21)                       e_en = 4'b0001;
      else if (s == 23)                                  e_busy = 1'b0;
      step((s <= 20) ? 4'b0001 : 4'b0000);
      chk_main($sformatf("sole.s%0d", s), e_en, e_lat, e_busy);
    end

    // --- DEAD_CYCLES=3 instance, req=0011 held ------------------------------
    gap = 0;
    for (int s = 1; s <= 20; s++) begin
      e_en = 4'b0000; e_lat = 1'b0; e_busy = 1'b1;
      if (s == 1 || s == 10)                 e_en = 4'b0001;
      else if (s >= 2 && s <= 9) begin
        e_en = 4'b0001; e_lat = 1'b1;
      end
      else if (s == 14 || s == 16)           e_en = 4'b0010;
      else if (s == 15) begin
        e_en = 4'b0010; e_lat = 1'b1;
      end
      else if (s == 20)                      e_busy = 1'b0;
      r3 = (s <= 14) ? 4'b0011 : 4'b0000;
      bus3.req = r3;
      step(4'b0000);
      chk_d3($sformatf("dead3.s%0d", s), e_en, e_lat, e_busy);
      if (s > 10 && s < 14 && bus3.drv_en == 4'b0000) gap++;
    end
    chk("dead3.gap", 32'(gap), 32'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
